// File: rtl/uart_transceiver_if.sv
// uart_transceiver_if: controller-facing bundle of the bit-level UART engine.
//   transmit, tx_byte      send request and the byte to send
//   clk_div_in             clk cycles per quarter bit (0 selects the built-in default)
//   received, rx_byte      one-cycle pulse with the byte just received
//   recv_error             one-cycle pulse on a framing error
//   is_receiving           receiver busy with a frame or recovering from an error
//   is_transmitting        transmitter busy with a frame
// master = UART controller, slave = transceiver.
interface uart_transceiver_if;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic [15:0] clk_div_in;
    logic        received;
    logic [7:0]  rx_byte;
    logic        is_receiving;
    logic        is_transmitting;
    logic        recv_error;
    modport master (
        output transmit, tx_byte, clk_div_in,
        input  received, rx_byte, is_receiving, is_transmitting, recv_error
    );
    modport slave (
        input  transmit, tx_byte, clk_div_in,
        output received, rx_byte, is_receiving, is_transmitting, recv_error
    );
endinterface

// File: rtl/uart_transceiver.sv
// uart_transceiver: 8N1 UART serializer/deserializer with 4x oversampled bit timing.
//   clk   system clock, everything on posedge
//   rst   asynchronous, active-low reset (0 = reset)
//   rx    serial input, asynchronous to clk, idle high
//   tx    serial output, idle high
//   bus   controller side (transmit/tx_byte/clk_div_in in; received/rx_byte/recv_error/
//         is_receiving/is_transmitting out)
// A quarter-bit tick comes from a per-direction down-counter reloaded with D-1, where
// D = clk_div_in, or CLOCK_DIVIDE when clk_div_in is 0. Four ticks make one bit.
module uart_transceiver #(
    parameter int CLOCK_DIVIDE = 108,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic             tx,
    uart_transceiver_if.slave bus
);
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_ERROR} rx_state_t;

    tx_state_t              tx_state, tx_state_nx;
    rx_state_t              rx_state, rx_state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [15:0]            div_m1;
    logic [15:0]            tx_cnt, rx_cnt;
    logic                   tx_tick, rx_tick;
    logic [1:0]             tx_q, rx_q;
    logic [3:0]             tx_bits;
    logic [2:0]             rx_bits;
    logic [9:0]             tx_shift;
    logic [7:0]             rx_shift;
    logic                   tx_bit_end, rx_bit_end, rx_mid_start, rx_stop_end;
    logic                   received_r, recv_error_r;
    logic [7:0]             rx_byte_r;

    assign div_m1       = (bus.clk_div_in == 16'd0) ? 16'(CLOCK_DIVIDE - 1) : bus.clk_div_in - 16'd1;
    assign rxs          = sync[SYNC_STAGES-1];
    assign tx_tick      = (tx_cnt == 16'd0);
    assign rx_tick      = (rx_cnt == 16'd0);
    assign tx_bit_end   = tx_tick && (tx_q == 2'd3);
    assign rx_bit_end   = rx_tick && (rx_q == 2'd3);
    assign rx_mid_start = rx_tick && (rx_q == 2'd1);
    assign rx_stop_end  = (rx_state == RX_STOP) && rx_bit_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
        end else begin
            tx_state <= tx_state_nx;
            rx_state <= rx_state_nx;
        end
    end

    always_comb begin
        tx_state_nx = (tx_state == TX_IDLE) ? (bus.transmit ? TX_SEND : TX_IDLE)
                                            : ((tx_bit_end && tx_bits == 4'd9) ? TX_IDLE : TX_SEND);
        rx_state_nx = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rxs) rx_state_nx = RX_START;
            RX_START: if (rx_mid_start) rx_state_nx = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bits == 3'd7) rx_state_nx = RX_STOP;
            RX_STOP:  if (rx_bit_end) rx_state_nx = rxs ? RX_IDLE : RX_ERROR;
            // rx_q counts consecutive high ticks here, so bit_end means four in a row
            RX_ERROR: if (rx_bit_end && rxs) rx_state_nx = RX_IDLE;
            default:  rx_state_nx = RX_IDLE;
        endcase
    end

    always_comb begin
        tx                  = (tx_state == TX_SEND) ? tx_shift[0] : 1'b1;
        bus.is_transmitting = (tx_state == TX_SEND);
        bus.is_receiving    = (rx_state != RX_IDLE);
        bus.received        = received_r;
        bus.recv_error      = recv_error_r;
        bus.rx_byte         = rx_byte_r;
    end

    // Dividers reload every cycle while idle, so leaving idle always starts a fresh bit period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync         <= '1;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            tx_bits      <= '0;
            rx_bits      <= '0;
            tx_shift     <= '1;
            rx_shift     <= '0;
            received_r   <= 1'b0;
            recv_error_r <= 1'b0;
            rx_byte_r    <= '0;
        end else begin
            sync         <= {sync[SYNC_STAGES-2:0], rx};
            tx_cnt       <= (tx_tick || tx_state == TX_IDLE) ? div_m1 : tx_cnt - 16'd1;
            rx_cnt       <= (rx_tick || rx_state == RX_IDLE) ? div_m1 : rx_cnt - 16'd1;
            tx_q         <= (tx_state == TX_IDLE) ? 2'd0 : (tx_tick ? tx_q + 2'd1 : tx_q);
            tx_bits      <= (tx_state == TX_IDLE) ? 4'd0 : (tx_bit_end ? tx_bits + 4'd1 : tx_bits);
            rx_bits      <= (rx_state != RX_DATA) ? 3'd0 : (rx_bit_end ? rx_bits + 3'd1 : rx_bits);
            received_r   <= rx_stop_end && rxs;
            recv_error_r <= rx_stop_end && !rxs;
            if (tx_state == TX_IDLE && bus.transmit)
                tx_shift <= {1'b1, bus.tx_byte, 1'b0};
            else if (tx_state == TX_SEND && tx_bit_end)
                tx_shift <= {1'b1, tx_shift[9:1]};
            // START realigns the quarter count at mid start bit; ERROR restarts it on any low tick
            if (rx_state == RX_IDLE)
                rx_q <= 2'd0;
            else if (rx_tick)
                rx_q <= ((rx_state == RX_START && rx_q == 2'd1) || (rx_state == RX_ERROR && !rxs))
                        ? 2'd0 : rx_q + 2'd1;
            if (rx_state == RX_DATA && rx_bit_end)
                rx_shift <= {rxs, rx_shift[7:1]};
            if (rx_stop_end && rxs)
                rx_byte_r <= rx_shift;
        end
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed self-checking bench for uart_transceiver.
module tb_uart_transceiver;
    logic clk = 1'b0;
    logic rst;
    logic rx_drv;
    logic loop;
    logic rx_line;
    logic tx;
    int   checks = 0;
    int   errors = 0;
    int   rcv_n = 0;
    int   err_n = 0;
    logic [7:0] rx_log [16];

    uart_transceiver_if bus();

    assign rx_line = loop ? tx : rx_drv;

    uart_transceiver dut (
        .clk(clk),
        .rst(rst),
        .rx(rx_line),
        .tx(tx),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.received) begin
            if (rcv_n < 16) rx_log[rcv_n] <= bus.rx_byte;
            rcv_n <= rcv_n + 1;
        end
        if (bus.recv_error) err_n <= err_n + 1;
    end

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (bus.received !== 1'b0) begin errors++; $display("FAIL reset_received got %b want 0", bus.received); end
        checks++; if (bus.recv_error !== 1'b0) begin errors++; $display("FAIL reset_recv_error got %b want 0", bus.recv_error); end
        checks++; if (bus.is_receiving !== 1'b0) begin errors++; $display("FAIL reset_is_receiving got %b want 0", bus.is_receiving); end
        checks++; if (bus.is_transmitting !== 1'b0) begin errors++; $display("FAIL reset_is_transmitting got %b want 0", bus.is_transmitting); end
        checks++; if (bus.rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want 00", bus.rx_byte); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx;
        logic [9:0] exp_bits;
        exp_bits = 10'b1101001010;
        bus.tx_byte  = 8'hA5;
        bus.transmit = 1'b1;
        @(negedge clk);
        bus.transmit = 1'b0;
        for (int k = 0; k < 160; k++) begin
            checks++;
            if (tx !== exp_bits[k/16] || bus.is_transmitting !== 1'b1) begin
                errors++;
                $display("FAIL tx_a5 cycle %0d got tx=%b busy=%b want tx=%b busy=1", k, tx, bus.is_transmitting, exp_bits[k/16]);
            end
            @(negedge clk);
        end
        checks++;
        if (tx !== 1'b1 || bus.is_transmitting !== 1'b0) begin
            errors++;
            $display("FAIL tx_a5_end got tx=%b busy=%b want tx=1 busy=0", tx, bus.is_transmitting);
        end
    endtask

    task automatic test_rx;
        int r0, e0;
        r0 = rcv_n; e0 = err_n;
        drive_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (rcv_n - r0 !== 1) begin errors++; $display("FAIL rx_3c_pulses got %0d want 1", rcv_n - r0); end
        checks++; if (err_n - e0 !== 0) begin errors++; $display("FAIL rx_3c_errors got %0d want 0", err_n - e0); end
        checks++; if (bus.rx_byte !== 8'h3C) begin errors++; $display("FAIL rx_3c_byte got %h want 3c", bus.rx_byte); end
        checks++; if (bus.is_receiving !== 1'b0) begin errors++; $display("FAIL rx_3c_idle got %b want 0", bus.is_receiving); end
    endtask

    task automatic test_framing_error;
        int r0, e0;
        r0 = rcv_n; e0 = err_n;
        drive_frame(8'hFF, 1'b0);
        repeat (32) @(negedge clk);
        checks++; if (err_n - e0 !== 1) begin errors++; $display("FAIL ferr_errors got %0d want 1", err_n - e0); end
        checks++; if (rcv_n - r0 !== 0) begin errors++; $display("FAIL ferr_pulses got %0d want 0", rcv_n - r0); end
        checks++; if (bus.rx_byte !== 8'h3C) begin errors++; $display("FAIL ferr_byte_held got %h want 3c", bus.rx_byte); end
        checks++; if (bus.is_receiving !== 1'b0) begin errors++; $display("FAIL ferr_recovered got %b want 0", bus.is_receiving); end
        r0 = rcv_n; e0 = err_n;
        drive_frame(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (rcv_n - r0 !== 1) begin errors++; $display("FAIL ferr_55_pulses got %0d want 1", rcv_n - r0); end
        checks++; if (err_n - e0 !== 0) begin errors++; $display("FAIL ferr_55_errors got %0d want 0", err_n - e0); end
        checks++; if (bus.rx_byte !== 8'h55) begin errors++; $display("FAIL ferr_55_byte got %h want 55", bus.rx_byte); end
    endtask

    task automatic test_glitch;
        int r0, e0, n;
        r0 = rcv_n; e0 = err_n;
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        checks++; if (bus.is_receiving !== 1'b1) begin errors++; $display("FAIL glitch_start got %b want 1", bus.is_receiving); end
        n = 0;
        while (bus.is_receiving === 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.is_receiving !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0 within 16", bus.is_receiving); end
        repeat (20) @(negedge clk);
        checks++; if (rcv_n - r0 !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", rcv_n - r0); end
        checks++; if (err_n - e0 !== 0) begin errors++; $display("FAIL glitch_errors got %0d want 0", err_n - e0); end
    endtask

    task automatic test_hold_and_reset;
        logic [9:0] got;
        got = '0;
        bus.tx_byte  = 8'h01;
        bus.transmit = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 160; k++) begin
            if (k == 0) bus.tx_byte = 8'hFF;
            if (k % 16 == 8) got[k/16] = tx;
            @(negedge clk);
        end
        checks++; if (got !== 10'b1000000010) begin errors++; $display("FAIL hold_frame got %b want 1000000010", got); end
        repeat (40) @(negedge clk);
        checks++; if (bus.is_transmitting !== 1'b1) begin errors++; $display("FAIL hold_resend got %b want 1", bus.is_transmitting); end
        #2 rst = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_rst_tx got %b want 1", tx); end
        checks++; if (bus.is_transmitting !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", bus.is_transmitting); end
        bus.transmit = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        int r0, e0, n;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
        bus.clk_div_in = 16'd0;
        loop = 1'b1;
        r0 = rcv_n; e0 = err_n;
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            bus.tx_byte  = bytes[b];
            bus.transmit = 1'b1;
            @(negedge clk);
            bus.transmit = 1'b0;
            n = 0;
            while (bus.is_transmitting === 1'b1 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            checks++; if (bus.is_transmitting !== 1'b0) begin errors++; $display("FAIL loop_tx_done byte %0d got busy=%b want 0", b, bus.is_transmitting); end
        end
        repeat (100) @(negedge clk);
        checks++; if (rcv_n - r0 !== 3) begin errors++; $display("FAIL loop_pulses got %0d want 3", rcv_n - r0); end
        checks++; if (err_n - e0 !== 0) begin errors++; $display("FAIL loop_errors got %0d want 0", err_n - e0); end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (rx_log[r0 + b] !== bytes[b]) begin
                errors++;
                $display("FAIL loop_byte %0d got %h want %h", b, rx_log[r0 + b], bytes[b]);
            end
        end
    endtask

    initial begin
        rst            = 1'b0;
        rx_drv         = 1'b1;
        loop           = 1'b0;
        bus.transmit   = 1'b0;
        bus.tx_byte    = 8'h00;
        bus.clk_div_in = 16'd4;
        test_reset;
        test_tx;
        test_rx;
        test_framing_error;
        test_glitch;
        test_hold_and_reset;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
